// File: rtl/fir_filter_seq.sv
// Time-multiplexed direct-form FIR filter: one multiply-accumulate per cycle over TAPS cycles,
// with a valid/ready handshake on both the sample input and the result output.
module fir_filter_seq #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 8,
  parameter logic [TAPS*COEFF_WIDTH-1:0] COEFFS = {8{16'sd1}},
  localparam int OUT_WIDTH  = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] iv_din,
  input  logic                  i_din_valid,
  output logic                  o_ready,
  output logic [OUT_WIDTH-1:0]  ov_dout,
  output logic                  o_dout_valid,
  input  logic                  i_ready
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int KW         = $clog2(TAPS);

  typedef enum logic [2:0] {
    StIdle   = 3'b001,
    StMac    = 3'b010,
    StOutput = 3'b100
  } state_e;

  state_e                        state_q;
  logic signed [DATA_WIDTH-1:0]  x_q [TAPS];
  logic signed [OUT_WIDTH-1:0]   acc_q;
  logic        [KW-1:0]          k_q;
  logic signed [OUT_WIDTH-1:0]   dout_q;
  logic                          dout_valid_q;

  logic signed [DATA_WIDTH-1:0]  x_sel;
  logic signed [COEFF_WIDTH-1:0] c_sel;
  logic signed [PROD_WIDTH-1:0]  prod;
  logic signed [OUT_WIDTH-1:0]   prod_ext;
  logic signed [OUT_WIDTH-1:0]   acc_sum;
  logic                          last_tap;

  // Single MAC datapath: operands are selected by the tap index each cycle.
  always_comb begin
    x_sel    = x_q[k_q];
    c_sel    = COEFFS[int'(k_q)*COEFF_WIDTH +: COEFF_WIDTH];
    prod     = x_sel * c_sel;
    prod_ext = {{(OUT_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
    last_tap = (k_q == KW'(TAPS-1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      k_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
      end
    end else if (i_en) begin
      unique case (state_q)
        StIdle: begin
          if (i_din_valid) begin
            for (int i = TAPS-1; i > 0; i--) begin
              x_q[i] <= x_q[i-1];
            end
            x_q[0]  <= signed'(iv_din);
            acc_q   <= '0;
            k_q     <= '0;
            state_q <= StMac;
          end
        end
        StMac: begin
          if (last_tap) begin
            dout_q       <= acc_sum;
            dout_valid_q <= 1'b1;
            state_q      <= StOutput;
          end else begin
            acc_q <= acc_sum;
            k_q   <= k_q + KW'(1);
          end
        end
        StOutput: begin
          if (i_ready) begin
            dout_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          dout_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  // Ready depends on the state register alone, so no input reaches it combinationally.
  assign o_ready      = (state_q == StIdle);
  assign ov_dout      = dout_q;
  assign o_dout_valid = dout_valid_q;

endmodule
